ga25_sdr_arbiter: RTL
=====================

// Module: ga25_sdr_arbiter
// PURPOSE
//  Shares one 32-bit SDRAM read port between the GA25 tile-layer fetchers (sdr_req/sdr_addr/sdr_rdy/sdr_data).
//  Each layer's one-cycle request is captured into a per-channel pending slot.
//  Slots are served round-robin, one outstanding SDRAM read at a time.
//  Returned row data is held per channel for the layer's shifter load.
//  Sits between the ga25_layer instances and the SDRAM controller's tile-ROM read channel.
// PARAMETERS
//  NUM_REQ  3   number of requester channels (layers); 1..8
//  AW       22  SDRAM word address width
//  DW       32  SDRAM data width
// PORTS
//  clk        in   1            system clock; all logic on posedge
//  reset      in   1            asynchronous, active-high reset
//  ch_req     in   NUM_REQ      per-channel request strobe, one clk wide
//  ch_addr    in   NUM_REQ*AW   per-channel address, valid with ch_req; channel i at [i*AW +: AW]
//  ch_data    out  NUM_REQ*DW   per-channel last returned row; held until the next return on that channel
//  ch_rdy     out  NUM_REQ      per-channel return strobe, one clk wide
//  ch_ovr     out  NUM_REQ      sticky overrun: a new ch_req arrived while that slot was still pending
//  ovr_clr    in   1            clears all ch_ovr bits
//  mem_req    out  1            level request to SDRAM; held until mem_rdy
//  mem_addr   out  AW           address for mem_req; stable while mem_req=1
//  mem_rdy    in   1            one-clk strobe; mem_data valid in the same cycle
//  mem_data   in   DW           SDRAM read data
// BEHAVIOUR
//  Reset values: mem_req=0, mem_addr=0, ch_data=0, ch_rdy=0, ch_ovr=0, all pending=0, rr pointer=0, state=IDLE.
//  Capture: ch_req[i] at edge t sets pend[i] and paddr[i]<=ch_addr[i].
//  - If pend[i] is already set and not being granted at t, the address is overwritten (latest wins) and ch_ovr[i] is set.
//  - If pend[i] is granted in the same cycle a new ch_req[i] arrives, the grant uses the old address.
//    pend[i] stays set with the new address; no overrun.
//  FSM:
//  - IDLE: if any pend, pick g = first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
//    Then register mem_addr<=paddr[g], mem_req<=1, clear pend[g], gsel<=g, rr_ptr<=g+1 (wrap), go to WAIT.
//  - WAIT: mem_req held. On mem_rdy: ch_data[gsel]<=mem_data, ch_rdy[gsel]<=1 for one clk, mem_req<=0, go to IDLE.
//  Latency:
//  - ch_req at t -> mem_req high from t+2.
//  - mem_rdy at r -> ch_rdy/ch_data visible at r+1.
//  - Next grant no earlier than mem_req at r+2.
//  - mem_req drops for at least one clk between reads.
//  mem_rdy in IDLE is a stray strobe and is ignored; no ch_* change.
//  Reset asserted mid-WAIT: the transaction is abandoned and all slots drop.
//  A late mem_rdy after reset is ignored by the IDLE rule.
//  ovr_clr has priority below a same-cycle new overrun (overrun wins).
//  No starvation: with all channels permanently pending, grants rotate 0,1,..,NUM_REQ-1,0.
//  Width rules: rr_ptr is $clog2(NUM_REQ) bits (min 1); increment wraps explicitly at NUM_REQ (non power of two).
// STRUCTURE
//  ga25_pkg holds:
//  - arb_state_t enum {ARB_IDLE, ARB_WAIT}
//  - GA25_SDR_AW=22 and GA25_SDR_DW=32, used as the parameter defaults.
//  Sub-module ga25_rr_pick (combinational):
//  - inputs pend[NUM_REQ-1:0] and ptr; outputs grant index and valid.
//  - reused by the sprite fetch arbiter.
//  Top level: capture regs, FSM, return demux.
// TESTING
//  1 Single request: ch_req[1] with addr 0x012340 at t -> mem_req=1, mem_addr=0x012340 at t+2.
//    mem_rdy with data 0xDEADBEEF at r -> ch_rdy=3'b010 and ch_data[1]=0xDEADBEEF at r+1.
//  2 Simultaneous requests: ch_req=3'b111 at one edge, mem_rdy 3 clks after each mem_req.
//    -> grant order 0,1,2; each ch_rdy single-clk; ch_ovr=0.
//  3 Overrun: ch_req[2] addr A, then addr B while ch2 is pending behind ch0's WAIT.
//    -> mem_addr=B for ch2, ch_ovr[2]=1; ovr_clr clears it.
//  4 Same-cycle grant and re-request on ch0 -> first read uses the old addr.
//    A second read follows with the new addr; ch_ovr[0]=0.
//  5 Reset mid-WAIT, then mem_rdy 2 clks after reset release.
//    -> no ch_rdy, ch_data=0, mem_req=0, pending cleared.
//  6 Fairness: all ch_req held every clk for 30 reads -> per-channel grant counts differ by at most 1.
//    Stray mem_rdy in IDLE causes no output change.

Source files
------------

// File: rtl/ga25_pkg.sv
// Shared types and defaults for the GA25 tile-fetch arbitration logic.
package ga25_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_t;

    localparam int GA25_SDR_AW = 22;
    localparam int GA25_SDR_DW = 32;

    // Round-robin pointer width; a single channel still needs one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ga25_rr_pick.sv
// Combinational round-robin picker: first pending index at or after ptr, wrapping.
module ga25_rr_pick
    import ga25_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int PW      = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pend,
    input  logic [PW-1:0]      ptr,
    output logic [PW-1:0]      grant,
    output logic               valid
);

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        // First pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && pend[i] && (PW'(i) >= ptr)) begin
                valid = 1'b1;
                grant = PW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && pend[i]) begin
                valid = 1'b1;
                grant = PW'(i);
            end
        end
    end

endmodule

// File: rtl/ga25_sdr_arbiter.sv
// Shares one SDRAM read port between the tile-layer fetchers, one outstanding read at a time.
module ga25_sdr_arbiter
    import ga25_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int AW      = GA25_SDR_AW,
    parameter int DW      = GA25_SDR_DW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    ch_req,
    input  logic [NUM_REQ*AW-1:0] ch_addr,
    output logic [NUM_REQ*DW-1:0] ch_data,
    output logic [NUM_REQ-1:0]    ch_rdy,
    output logic [NUM_REQ-1:0]    ch_ovr,
    input  logic                  ovr_clr,
    output logic                  mem_req,
    output logic [AW-1:0]         mem_addr,
    input  logic                  mem_rdy,
    input  logic [DW-1:0]         mem_data
);

    localparam int PW = ptr_w(NUM_REQ);

    arb_state_t          state, state_nxt;
    logic [NUM_REQ-1:0]  pend;
    logic [AW-1:0]       paddr [NUM_REQ];
    logic [NUM_REQ-1:0]  grant_mask;
    logic [NUM_REQ-1:0]  ret_mask;
    logic [NUM_REQ-1:0]  ovr_set;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       gsel;
    logic [PW-1:0]       pick_idx;
    logic [PW-1:0]       ptr_nxt;
    logic [AW-1:0]       pick_addr;
    logic                pick_vld;
    logic                grant_go;
    logic                ret_go;

    ga25_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .pend  (pend),
        .ptr   (rr_ptr),
        .grant (pick_idx),
        .valid (pick_vld)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_go  = 1'b0;
        ret_go    = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (pick_vld) begin
                    grant_go  = 1'b1;
                    state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mem_rdy) begin
                    ret_go    = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant_mask = '0;
        ret_mask   = '0;
        pick_addr  = paddr[0];
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_mask[i] = grant_go && (pick_idx == PW'(i));
            ret_mask[i]   = ret_go && (gsel == PW'(i));
            if (pick_idx == PW'(i)) begin
                pick_addr = paddr[i];
            end
        end
        // A slot granted this very edge hands off its old address, so a re-request is not an overrun.
        ovr_set = ch_req & pend & ~grant_mask;
        ptr_nxt = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend   <= '0;
            ch_ovr <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ch_req[i]) begin
                    pend[i] <= 1'b1;
                end else if (grant_mask[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            // A fresh overrun outranks a same-cycle clear.
            ch_ovr <= (ovr_clr ? '0 : ch_ovr) | ovr_set;
        end
    end

    // NOTE: pending addresses are only read while their pend bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ch_req[i]) begin
                paddr[i] <= ch_addr[i*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            gsel     <= '0;
            rr_ptr   <= '0;
        end else if (grant_go) begin
            mem_req  <= 1'b1;
            mem_addr <= pick_addr;
            gsel     <= pick_idx;
            rr_ptr   <= ptr_nxt;
        end else if (ret_go) begin
            mem_req  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_data <= '0;
            ch_rdy  <= '0;
        end else begin
            ch_rdy <= ret_mask;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ret_mask[i]) begin
                    ch_data[i*DW +: DW] <= mem_data;
                end
            end
        end
    end

endmodule
